// File: rtl/filt_ppi_tdm_pkg.sv
// Shared types and elaboration-time helpers for the time-multiplexed polyphase interpolator.
package filt_ppi_tdm_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StMac,
        StOut
    } ppi_state_e;

    // Ceiling log2, never below 1 so it can always size a vector.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(v)) begin
                r = unsigned'(i + 1);
            end
        end
        return (r == 0) ? 1 : r;
    endfunction

    function automatic int unsigned div(input int unsigned a, input int unsigned b);
        return a / b;
    endfunction

    // Taps per phase of the prototype filter.
    function automatic int unsigned taps_per_phase(input int unsigned len,
                                                   input int unsigned max_interp);
        int unsigned t;
        t = div(len, max_interp);
        return (t == 0) ? 1 : t;
    endfunction

    // Accumulator width: full product plus growth over TP terms plus one guard bit.
    function automatic int unsigned acc_width(input int unsigned idw, input int unsigned cw,
                                              input int unsigned tp);
        return idw + cw + clog2(tp) + 1;
    endfunction

endpackage

// File: rtl/filt_ppi_tdm_coeff_ram.sv
// Coefficient store: one write port, one registered read port. Storage is never reset.
module filt_ppi_tdm_coeff_ram #(
    parameter int unsigned gp_depth      = 64,
    parameter int unsigned gp_addr_width = 6,
    parameter int unsigned gp_data_width = 16
) (
    input  logic                     i_clk,
    input  logic                     i_we,
    input  logic [gp_addr_width-1:0] i_waddr,
    input  logic [gp_data_width-1:0] i_wdata,
    input  logic                     i_re,
    input  logic [gp_addr_width-1:0] i_raddr,
    output logic [gp_data_width-1:0] o_rdata
);

    logic [gp_data_width-1:0] mem [gp_depth];

    // Write lands at the clock edge; read data appears one cycle after the address.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            mem[i_waddr] <= i_wdata;
        end
        if (i_re) begin
            o_rdata <= mem[i_raddr];
        end
    end

endmodule

// File: rtl/filt_ppi_tdm.sv
// Time-multiplexed polyphase interpolator: one serial MAC, coefficient RAM, valid/ready both sides.
// Build option FILT_PPI_TDM_SAT_EN: round half-up and saturate the output instead of truncating.
module filt_ppi_tdm
    import filt_ppi_tdm_pkg::*;
#(
    parameter int unsigned gp_idata_width  = 8,
    parameter int unsigned gp_coeff_width  = 16,
    parameter int unsigned gp_max_interp   = 32,
    parameter int unsigned gp_coeff_length = 64,
    parameter int unsigned gp_odata_width  = 24,
    parameter int unsigned gp_shift        = 0
) (
    input  logic                                       i_clk,
    input  logic                                       i_rst_an,
    input  logic                                       i_ena,
    input  logic [clog2(gp_max_interp):0]              i_l,
    input  logic                                       i_valid,
    output logic                                       o_ready,
    input  logic [gp_idata_width-1:0]                  i_data,
    output logic                                       o_valid,
    input  logic                                       i_ready,
    output logic [gp_odata_width-1:0]                  o_data,
    output logic [clog2(gp_max_interp)-1:0]            o_phase,
    input  logic                                       i_cwr,
    input  logic [clog2(gp_max_interp *
                  taps_per_phase(gp_coeff_length, gp_max_interp))-1:0] i_caddr,
    input  logic [gp_coeff_width-1:0]                  i_cdata,
    output logic                                       o_cwr_err
);

    localparam int unsigned TP     = taps_per_phase(gp_coeff_length, gp_max_interp);
    localparam int unsigned ACC_W  = acc_width(gp_idata_width, gp_coeff_width, TP);
    localparam int unsigned PW     = clog2(gp_max_interp);
    localparam int unsigned LW     = PW + 1;
    localparam int unsigned AW     = clog2(gp_max_interp * TP);
    localparam int unsigned KW     = clog2(TP + 1);
    localparam int unsigned PROD_W = gp_idata_width + gp_coeff_width;
    localparam int unsigned ODW    = gp_odata_width;

    ppi_state_e                        state_q, state_d;
    logic [KW-1:0]                     k_q, k_d;
    logic [PW-1:0]                     p_q, p_d;
    logic [PW-1:0]                     lm1_q, lm1_d;
    logic signed [ACC_W-1:0]           acc_q, acc_d;
    logic [ODW-1:0]                    data_q, data_d;
    logic                              cwr_err_q;
    logic                              shift_en;
    logic signed [gp_idata_width-1:0]  x_q [TP];
    logic signed [gp_idata_width-1:0]  tap;
    logic signed [PROD_W-1:0]          prod;
    logic [gp_coeff_width-1:0]         rdata;
    logic                              ram_we;
    logic                              ram_re;
    logic [AW-1:0]                     ram_raddr;

    // Effective L minus one: 0 means L=1, oversize requests clamp to the maximum.
    function automatic logic [PW-1:0] clamp_lm1(input logic [LW-1:0] l);
        if (l == '0) begin
            return '0;
        end
        if (l > LW'(gp_max_interp)) begin
            return PW'(gp_max_interp - 1);
        end
        return PW'(l - 1'b1);
    endfunction

`ifdef FILT_PPI_TDM_SAT_EN
    localparam int unsigned RW = ACC_W + 1;
    localparam logic signed [RW-1:0] RND    = (RW'(1) << gp_shift) >> 1;
    localparam logic signed [RW-1:0] SAT_HI = (RW'(1) << (ODW - 1)) - RW'(1);
    localparam logic signed [RW-1:0] SAT_LO = -SAT_HI - RW'(1);

    function automatic logic [ODW-1:0] scale(input logic signed [ACC_W-1:0] a);
        logic signed [RW-1:0] r;
        r = RW'(a) + RND;
        r = r >>> gp_shift;
        if (r > SAT_HI) begin
            return SAT_HI[ODW-1:0];
        end
        if (r < SAT_LO) begin
            return SAT_LO[ODW-1:0];
        end
        return r[ODW-1:0];
    endfunction
`else
    function automatic logic [ODW-1:0] scale(input logic signed [ACC_W-1:0] a);
        return a[gp_shift +: ODW];
    endfunction
`endif

    // Handshakes are blocked while frozen so no transfer can be lost.
    assign o_ready   = i_ena && (state_q == StIdle);
    assign o_valid   = i_ena && (state_q == StOut);
    assign o_data    = data_q;
    assign o_phase   = p_q;
    assign o_cwr_err = cwr_err_q;

    // Reads run one cycle ahead of the accumulate: cycle k reads tap k, accumulates tap k-1.
    assign ram_we    = i_ena && i_cwr && (state_q == StIdle);
    assign ram_re    = i_ena && (state_q == StMac) && (k_q != KW'(TP));
    assign ram_raddr = AW'(p_q) * AW'(TP) + AW'(k_q);

    filt_ppi_tdm_coeff_ram #(
        .gp_depth      (gp_max_interp * TP),
        .gp_addr_width (AW),
        .gp_data_width (gp_coeff_width)
    ) u_coeff_ram (
        .i_clk   (i_clk),
        .i_we    (ram_we),
        .i_waddr (i_caddr),
        .i_wdata (i_cdata),
        .i_re    (ram_re),
        .i_raddr (ram_raddr),
        .o_rdata (rdata)
    );

    // Select the delay-line tap matching the coefficient fetched last cycle.
    always_comb begin
        tap = '0;
        for (int i = 0; i < int'(TP); i++) begin
            if (k_q == KW'(i + 1)) begin
                tap = x_q[i];
            end
        end
        prod = tap * $signed(rdata);
    end

    // Delay line: newest sample at index 0, shifted on input acceptance.
    always_ff @(posedge i_clk or negedge i_rst_an) begin
        if (!i_rst_an) begin
            for (int i = 0; i < int'(TP); i++) begin
                x_q[i] <= '0;
            end
        end else if (i_ena && shift_en) begin
            x_q[0] <= i_data;
            for (int i = 1; i < int'(TP); i++) begin
                x_q[i] <= x_q[i-1];
            end
        end
    end

    // Next-state logic for the IDLE -> MAC -> OUT sequencer and the datapath it controls.
    always_comb begin
        state_d  = state_q;
        k_d      = k_q;
        p_d      = p_q;
        lm1_d    = lm1_q;
        acc_d    = acc_q;
        data_d   = data_q;
        shift_en = 1'b0;
        case (state_q)
            StIdle: begin
                if (i_valid) begin
                    shift_en = 1'b1;
                    lm1_d    = clamp_lm1(i_l);
                    p_d      = '0;
                    k_d      = '0;
                    acc_d    = '0;
                    state_d  = StMac;
                end
            end
            StMac: begin
                if (k_q != '0) begin
                    acc_d = acc_q + ACC_W'(prod);
                end
                if (k_q == KW'(TP)) begin
                    data_d  = scale(acc_d);
                    state_d = StOut;
                end else begin
                    k_d = k_q + 1'b1;
                end
            end
            StOut: begin
                if (i_ready) begin
                    if (p_q == lm1_q) begin
                        state_d = StIdle;
                    end else begin
                        p_d     = p_q + 1'b1;
                        k_d     = '0;
                        acc_d   = '0;
                        state_d = StMac;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Control and datapath registers; everything holds while i_ena is low.
    always_ff @(posedge i_clk or negedge i_rst_an) begin
        if (!i_rst_an) begin
            state_q   <= StIdle;
            k_q       <= '0;
            p_q       <= '0;
            lm1_q     <= '0;
            acc_q     <= '0;
            data_q    <= '0;
            cwr_err_q <= 1'b0;
        end else if (i_ena) begin
            state_q   <= state_d;
            k_q       <= k_d;
            p_q       <= p_d;
            lm1_q     <= lm1_d;
            acc_q     <= acc_d;
            data_q    <= data_d;
            cwr_err_q <= i_cwr && (state_q != StIdle);
        end
    end

endmodule
